// File: rtl/vga_pmod_tx.sv
// TinyVGA PMOD transmitter: 640x480@60 timing generator with four test patterns,
// packing syncs and 2-bit RGB into the PMOD byte with one cycle of output latency.
module vga_pmod_tx #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] pattern_sel,
  output logic [7:0] pmod_out,
  output logic       video_active,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [6:0] BAR_LAST   = 7'd79;
  localparam logic [15:0] LCG_MUL   = 16'h5851;
  localparam logic [15:0] LCG_ADD   = 16'h1405;

  logic [9:0]  r_h;
  logic [9:0]  r_v;
  logic [7:0]  r_frameCnt;
  logic [6:0]  r_barCnt;
  logic [2:0]  r_barIdx;
  logic [1:0]  r_pattern;
  logic [15:0] r_lcg;
  logic [7:0]  r_pmod;
  logic        r_active;
  logic [9:0]  r_pixX;
  logic [9:0]  r_pixY;
  logic        r_frameStart;

  logic        w_hLast;
  logic        w_vLast;
  logic        w_origin;
  logic        w_visible;
  logic        w_hsync;
  logic        w_vsync;
  logic [1:0]  w_pattern;
  logic [15:0] w_lcgCur;
  logic [15:0] w_lcgNext;
  logic        w_checkOn;
  logic [1:0]  w_r;
  logic [1:0]  w_g;
  logic [1:0]  w_b;
  logic [7:0]  w_pmod;

  assign w_hLast   = (r_h == H_LAST);
  assign w_vLast   = (r_v == V_LAST);
  assign w_origin  = (r_h == 10'd0) && (r_v == 10'd0);
  assign w_visible = (r_h < H_VIS) && (r_v < V_VIS);
  assign w_hsync   = !((r_h >= HS_FIRST) && (r_h <= HS_LAST));
  assign w_vsync   = !((r_v >= VS_FIRST) && (r_v <= VS_LAST));

  // The pattern and LCG seed taken at the origin apply to the origin pixel itself.
  assign w_pattern = w_origin ? pattern_sel : r_pattern;
  assign w_lcgCur  = w_origin ? {8'h00, r_frameCnt} : r_lcg;
  assign w_lcgNext = w_lcgCur * LCG_MUL + LCG_ADD;

  // Bit 5 of (x + frame) rebuilt from the carry out of the low five bits.
  assign w_checkOn = r_h[5] ^ r_frameCnt[5] ^ r_v[5]
                   ^ (({1'b0, r_h[4:0]} + {1'b0, r_frameCnt[4:0]}) > 6'd31);

  always_comb begin
    w_r = 2'b00;
    w_g = 2'b00;
    w_b = 2'b00;
    if (w_visible) begin
      case (w_pattern)
        2'd1: begin
          w_r = {2{r_barIdx[0]}};
          w_g = {2{r_barIdx[1]}};
          w_b = {2{r_barIdx[2]}};
        end
        2'd2: begin
          w_r = {2{w_checkOn}};
          w_g = {2{w_checkOn}};
          w_b = {2{w_checkOn}};
        end
        2'd3: begin
          w_r = w_lcgCur[15:14];
          w_g = w_lcgCur[13:12];
          w_b = w_lcgCur[11:10];
        end
        default: ;
      endcase
    end
  end

  assign w_pmod = {w_hsync, w_b[0], w_g[0], w_r[0], w_vsync, w_b[1], w_g[1], w_r[1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h        <= 10'd0;
      r_v        <= 10'd0;
      r_frameCnt <= 8'd0;
    end else if (en) begin
      r_h <= w_hLast ? 10'd0 : r_h + 10'd1;
      if (w_hLast) begin
        r_v <= w_vLast ? 10'd0 : r_v + 10'd1;
        if (w_vLast)
          r_frameCnt <= r_frameCnt + 8'd1;
      end
    end
  end

  // Bars are 80 pixels wide; a counter tracks the bar edge so no divide is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_barCnt <= 7'd0;
      r_barIdx <= 3'd0;
    end else if (en) begin
      if (w_hLast) begin
        r_barCnt <= 7'd0;
        r_barIdx <= 3'd0;
      end else if (r_barCnt == BAR_LAST) begin
        r_barCnt <= 7'd0;
        if (r_barIdx != 3'd7)
          r_barIdx <= r_barIdx + 3'd1;
      end else begin
        r_barCnt <= r_barCnt + 7'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pattern <= 2'd0;
      r_lcg     <= 16'h0000;
    end else if (en) begin
      if (w_origin)
        r_pattern <= pattern_sel;
      if (w_visible)
        r_lcg <= w_lcgNext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pmod       <= 8'h88;
      r_active     <= 1'b0;
      r_pixX       <= 10'd0;
      r_pixY       <= 10'd0;
      r_frameStart <= 1'b0;
    end else if (en) begin
      r_pmod       <= w_pmod;
      r_active     <= w_visible;
      r_pixX       <= r_h;
      r_pixY       <= r_v;
      r_frameStart <= w_origin;
    end
  end

  assign pmod_out     = r_pmod;
  assign video_active = r_active;
  assign pix_x        = r_pixX;
  assign pix_y        = r_pixY;
  assign frame_start  = r_frameStart;
  assign frame_cnt    = r_frameCnt;

endmodule

// File: tb/tb_vga_pmod_tx.sv
// Directed bench for vga_pmod_tx: full-width lines with a short frame for speed,
// plus a tiny-timing instance that exercises the 255->0 frame counter wrap.
module tb_vga_pmod_tx;

  localparam int MV_ACTIVE = 8;
  localparam int MV_FP     = 2;
  localparam int MV_SYNC   = 2;
  localparam int MV_BP     = 2;
  localparam int LINES     = MV_ACTIVE + MV_FP + MV_SYNC + MV_BP;
  localparam int FRAME     = LINES * 800;
  localparam int SMALL_FRAME = 11 * 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [1:0] patternSel = 2'd1;
  logic [7:0] pmod_out;
  logic       video_active;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       frame_start;
  logic [7:0] frame_cnt;

  logic       rstS = 1'b0;
  logic       enS = 1'b1;
  logic [1:0] patS = 2'd0;
  logic [7:0] pmodS;
  logic       activeS;
  logic [9:0] pxS;
  logic [9:0] pyS;
  logic       fsS;
  logic [7:0] fcS;

  int checks = 0;
  int failures = 0;
  logic [7:0] capt [0:FRAME-1];

  vga_pmod_tx #(
    .V_ACTIVE(MV_ACTIVE), .V_FP(MV_FP), .V_SYNC(MV_SYNC), .V_BP(MV_BP)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pattern_sel(patternSel),
    .pmod_out(pmod_out), .video_active(video_active), .pix_x(pix_x),
    .pix_y(pix_y), .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  vga_pmod_tx #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dutSmall (
    .clk(clk), .rst(rstS), .en(enS), .pattern_sel(patS),
    .pmod_out(pmodS), .video_active(activeS), .pix_x(pxS),
    .pix_y(pyS), .frame_start(fsS), .frame_cnt(fcS)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] packPmod(input bit hs, input bit vs,
                                          input logic [1:0] r, input logic [1:0] g,
                                          input logic [1:0] b);
    return {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]};
  endfunction

  // Reference pixel for position (x,y) given the pattern, frame number and LCG state.
  function automatic logic [7:0] modelPixel(input int x, input int y, input int pat,
                                            input int fc, input logic [15:0] lcg);
    bit vis = (x < 640) && (y < MV_ACTIVE);
    bit hs = !((x >= 656) && (x < 752));
    bit vs = !((y >= MV_ACTIVE + MV_FP) && (y < MV_ACTIVE + MV_FP + MV_SYNC));
    logic [1:0] r = 2'b00;
    logic [1:0] g = 2'b00;
    logic [1:0] b = 2'b00;
    logic [2:0] k;
    bit on;
    if (vis) begin
      case (pat)
        1: begin
          k = 3'(x / 80);
          r = {2{k[0]}};
          g = {2{k[1]}};
          b = {2{k[2]}};
        end
        2: begin
          on = ((((x + (fc % 256)) >> 5) & 1) != ((y >> 5) & 1));
          r = on ? 2'b11 : 2'b00;
          g = r;
          b = r;
        end
        3: begin
          r = lcg[15:14];
          g = lcg[13:12];
          b = lcg[11:10];
        end
        default: ;
      endcase
    end
    return packPmod(hs, vs, r, g, b);
  endfunction

  task automatic waitPixel(input int x, input int y, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      if (pix_x == 10'(x) && pix_y == 10'(y))
        found = 1'b1;
      else
        @(negedge clk);
    end
    checkOutput($sformatf("reach (%0d,%0d)", x, y), 32'(found), 32'd1);
  endtask

  // Walks one frame from the (0,0) sample, comparing every byte to the model and
  // tallying sync/active widths; leaves the bench at the next frame's (0,0) sample.
  task automatic applyStimulus(input int pat, input int fc, input int switchTo);
    logic [15:0] lcg = 16'(fc % 256);
    int posErr = 0, pixErr = 0, lineErr = 0;
    int vsLow = 0, active = 0, fsCount = 0, hsLine = 0, actLine = 0;
    int x, y;
    checkOutput($sformatf("frame_cnt at start of frame %0d", fc), 32'(frame_cnt), 32'(fc % 256));
    for (int i = 0; i < FRAME; i++) begin
      x = i % 800;
      y = i / 800;
      if (x == 0) begin
        hsLine = 0;
        actLine = 0;
      end
      if (pix_x != 10'(x) || pix_y != 10'(y)) posErr++;
      if (pmod_out !== modelPixel(x, y, pat, fc, lcg)) pixErr++;
      capt[i] = pmod_out;
      if (pmod_out[7] == 1'b0) hsLine++;
      if (pmod_out[3] == 1'b0) vsLow++;
      if (video_active) begin
        active++;
        actLine++;
      end
      if (frame_start) fsCount++;
      if (x == 799) begin
        if (hsLine != 96) lineErr++;
        if (actLine != ((y < MV_ACTIVE) ? 640 : 0)) lineErr++;
      end
      if (x < 640 && y < MV_ACTIVE)
        lcg = lcg * 16'h5851 + 16'h1405;
      if (switchTo >= 0 && x == 300 && y == 5)
        patternSel = 2'(switchTo);
      @(negedge clk);
    end
    checkOutput($sformatf("frame %0d position errors", fc), 32'(posErr), 32'd0);
    checkOutput($sformatf("frame %0d pixel errors", fc), 32'(pixErr), 32'd0);
    checkOutput($sformatf("frame %0d line width errors", fc), 32'(lineErr), 32'd0);
    checkOutput($sformatf("frame %0d vsync low clocks", fc), 32'(vsLow), 32'd1600);
    checkOutput($sformatf("frame %0d active clocks", fc), 32'(active), 32'(640 * MV_ACTIVE));
    checkOutput($sformatf("frame %0d frame_start pulses", fc), 32'(fsCount), 32'd1);
  endtask

  task automatic freezeCheck(input string tag);
    logic [7:0] hPmod = pmod_out;
    logic       hAct = video_active;
    logic [9:0] hx = pix_x;
    logic [9:0] hy = pix_y;
    logic       hFs = frame_start;
    logic [7:0] hFc = frame_cnt;
    int errs = 0;
    en = 1'b0;
    repeat (7) begin
      @(negedge clk);
      if (pmod_out !== hPmod || video_active !== hAct || pix_x !== hx ||
          pix_y !== hy || frame_start !== hFs || frame_cnt !== hFc) errs++;
    end
    en = 1'b1;
    @(negedge clk);
    checkOutput({tag, " hold errors"}, 32'(errs), 32'd0);
    checkOutput({tag, " resume x"}, 32'(pix_x), 32'(hx) + 32'd1);
    checkOutput({tag, " resume y"}, 32'(pix_y), 32'(hy));
    checkOutput({tag, " resume frame_start"}, 32'(frame_start), 32'd0);
  endtask

  initial begin
    #1 rst = 1'b1;
    rstS = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset pmod_out", 32'(pmod_out), 32'h88);
    checkOutput("reset video_active", 32'(video_active), 32'd0);
    checkOutput("reset pix_x", 32'(pix_x), 32'd0);
    checkOutput("reset pix_y", 32'(pix_y), 32'd0);
    checkOutput("reset frame_start", 32'(frame_start), 32'd0);
    checkOutput("reset frame_cnt", 32'(frame_cnt), 32'd0);

    rst = 1'b0;
    en = 1'b1;
    @(negedge clk);
    checkOutput("first pixel x", 32'(pix_x), 32'd0);
    checkOutput("first pixel y", 32'(pix_y), 32'd0);
    checkOutput("first pixel frame_start", 32'(frame_start), 32'd1);

    $display("[TB] colour bars frame, switching to checker mid-frame");
    applyStimulus(1, 0, 2);
    checkOutput("bars (0,0)", 32'(capt[0]), 32'h88);
    checkOutput("bars (80,0)", 32'(capt[80]), 32'h99);
    checkOutput("bars (639,0)", 32'(capt[639]), 32'hFF);
    checkOutput("bars (640,0)", 32'(capt[640]), 32'h88);
    checkOutput("bars hsync (700,0)", 32'(capt[700]), 32'h08);
    checkOutput("bars after switch (80,6)", 32'(capt[6 * 800 + 80]), 32'h99);
    checkOutput("vsync line (100,10)", 32'(capt[10 * 800 + 100]), 32'h80);
    checkOutput("both syncs (700,10)", 32'(capt[10 * 800 + 700]), 32'h00);

    $display("[TB] checker frame 1");
    applyStimulus(2, 1, -1);
    checkOutput("checker f1 (30,0)", 32'(capt[30]), 32'h88);
    checkOutput("checker f1 (31,0)", 32'(capt[31]), 32'hFF);
    checkOutput("checker f1 (31,9)", 32'(capt[9 * 800 + 31]), 32'h88);

    $display("[TB] en freeze in frame 2");
    checkOutput("f2 origin frame_start", 32'(frame_start), 32'd1);
    freezeCheck("freeze at origin");
    waitPixel(40, 0, 100);
    checkOutput("checker f2 (40,0)", 32'(pmod_out), 32'hFF);
    freezeCheck("freeze at (40,0)");

    $display("[TB] asynchronous reset mid-line, then noise");
    patternSel = 2'd3;
    waitPixel(500, 3, 5000);
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset pmod_out", 32'(pmod_out), 32'h88);
    checkOutput("async reset frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("async reset video_active", 32'(video_active), 32'd0);
    checkOutput("async reset pix_x", 32'(pix_x), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post-reset frame_start", 32'(frame_start), 32'd1);
    checkOutput("post-reset pix_x", 32'(pix_x), 32'd0);
    applyStimulus(3, 0, -1);
    checkOutput("noise f0 (0,0)", 32'(capt[0]), 32'h88);
    checkOutput("noise f0 (1,0)", 32'(capt[1]), 32'hE8);
    applyStimulus(3, 1, -1);
    checkOutput("noise f1 (0,0)", 32'(capt[0]), 32'h88);
    checkOutput("noise f1 (1,0)", 32'(capt[1]), 32'hDE);

    $display("[TB] frame counter wrap on small-timing instance");
    rstS = 1'b0;
    @(negedge clk);
    checkOutput("small first frame_start", 32'(fsS), 32'd1);
    checkOutput("small first frame_cnt", 32'(fcS), 32'd0);
    repeat (SMALL_FRAME * 255) @(negedge clk);
    checkOutput("small frame 255 frame_cnt", 32'(fcS), 32'd255);
    checkOutput("small frame 255 frame_start", 32'(fsS), 32'd1);
    repeat (SMALL_FRAME) @(negedge clk);
    checkOutput("small wrap frame_cnt", 32'(fcS), 32'd0);
    checkOutput("small wrap frame_start", 32'(fsS), 32'd1);
    checkOutput("small wrap pix_x", 32'(pxS), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
